// File: rtl/complex_dot_accum.sv
// rtl/complex_dot_accum.sv - streaming complex accumulator summing TERMS products per result
//
// Purpose:
//   Sits downstream of the complex multiplier. Sums TERMS consecutive accepted
//   complex beats (re, im) into one complex result. The accumulator carries
//   GUARD_W extra MSBs, so the running sum cannot wrap while TERMS <= 2^GUARD_W.
//   The final sum is narrowed back to DATA_W bits. out_ovf flags a result that
//   did not fit DATA_W.
//
// Optional feature (macro COMPLEX_DOT_ACCUM_SAT_EN):
//   defined   - an overflowing component clamps to the most positive or most
//               negative DATA_W value, chosen by the accumulator sign.
//   undefined - an overflowing component keeps the low DATA_W bits (wraps).
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       product beat valid
//   in_ready   out  1       beat accepted this cycle (high in ACCUM)
//   in_re      in   DATA_W  signed real part of product
//   in_im      in   DATA_W  signed imaginary part of product
//   flush      in   1       clears the partial sum in ACCUM; ignored in HOLD
//   out_valid  out  1       result valid (high in HOLD)
//   out_ready  in   1       consumer accepts result
//   out_re     out  DATA_W  signed real sum
//   out_im     out  DATA_W  signed imaginary sum
//   out_ovf    out  1       either component of the final sum overflowed DATA_W

module complex_dot_accum #(
  parameter int DATA_W  = 32,
  parameter int TERMS   = 4,
  parameter int GUARD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_ovf
);

  localparam int ACC_W = DATA_W + GUARD_W;
  localparam int CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TERMS - 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_count;
  logic [ACC_W-1:0]  r_acc_re;
  logic [ACC_W-1:0]  r_acc_im;
  logic [DATA_W-1:0] r_out_re;
  logic [DATA_W-1:0] r_out_im;
  logic              r_out_ovf;

  logic              w_accept;
  logic              w_last;
  logic              w_done;
  logic [ACC_W-1:0]  w_sum_re;
  logic [ACC_W-1:0]  w_sum_im;
  logic              w_ovf_re;
  logic              w_ovf_im;
  logic [DATA_W-1:0] w_res_re;
  logic [DATA_W-1:0] w_res_im;

  // The value fits DATA_W exactly when every bit from the DATA_W sign bit up
  // to the accumulator MSB is identical.
  function automatic logic does_overflow(input logic [ACC_W-1:0] v);
    return !((&v[ACC_W-1:DATA_W-1]) | ~(|v[ACC_W-1:DATA_W-1]));
  endfunction

`ifdef COMPLEX_DOT_ACCUM_SAT_EN
  function automatic logic [DATA_W-1:0] narrow(input logic [ACC_W-1:0] v);
    if (does_overflow(v)) begin
      if (v[ACC_W-1]) return {1'b1, {(DATA_W-1){1'b0}}};
      else            return {1'b0, {(DATA_W-1){1'b1}}};
    end
    return v[DATA_W-1:0];
  endfunction
`else
  function automatic logic [DATA_W-1:0] narrow(input logic [ACC_W-1:0] v);
    return v[DATA_W-1:0];
  endfunction
`endif

  // A flush in ACCUM discards any coincident beat, so it blocks acceptance.
  assign w_accept = in_valid && (r_state == ST_ACCUM) && !flush;
  assign w_last   = (r_count == LAST_CNT);
  assign w_done   = w_accept && w_last;

  assign w_sum_re = r_acc_re + {{GUARD_W{in_re[DATA_W-1]}}, in_re};
  assign w_sum_im = r_acc_im + {{GUARD_W{in_im[DATA_W-1]}}, in_im};
  assign w_ovf_re = does_overflow(w_sum_re);
  assign w_ovf_im = does_overflow(w_sum_im);
  assign w_res_re = narrow(w_sum_re);
  assign w_res_im = narrow(w_sum_im);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (w_done) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = ST_ACCUM;
      end
      default: w_state_next = ST_ACCUM;
    endcase
  end

  // The result registers load only on the completing beat, so they stay
  // stable through HOLD regardless of backpressure or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_acc_re  <= '0;
      r_acc_im  <= '0;
      r_out_re  <= '0;
      r_out_im  <= '0;
      r_out_ovf <= 1'b0;
    end else if (r_state == ST_ACCUM) begin
      if (flush) begin
        r_count  <= '0;
        r_acc_re <= '0;
        r_acc_im <= '0;
      end else if (w_accept) begin
        if (w_last) begin
          r_count   <= '0;
          r_acc_re  <= '0;
          r_acc_im  <= '0;
          r_out_re  <= w_res_re;
          r_out_im  <= w_res_im;
          r_out_ovf <= w_ovf_re | w_ovf_im;
        end else begin
          r_count  <= r_count + CNT_W'(1);
          r_acc_re <= w_sum_re;
          r_acc_im <= w_sum_im;
        end
      end
    end
  end

  assign out_re  = r_out_re;
  assign out_im  = r_out_im;
  assign out_ovf = r_out_ovf;

endmodule

// File: tb/tb_complex_dot_accum.sv
// tb/tb_complex_dot_accum.sv - directed self-checking bench for complex_dot_accum

module tb_complex_dot_accum;

`ifdef COMPLEX_DOT_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_re = '0;
  logic [31:0] in_im = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_re;
  logic [31:0] out_im;
  logic        out_ovf;

  logic        t1_in_valid = 1'b0;
  logic        t1_in_ready;
  logic [31:0] t1_in_re = '0;
  logic [31:0] t1_in_im = '0;
  logic        t1_out_valid;
  logic        t1_out_ready = 1'b0;
  logic [31:0] t1_out_re;
  logic [31:0] t1_out_im;
  logic        t1_out_ovf;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  complex_dot_accum #(.DATA_W(32), .TERMS(4), .GUARD_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_ovf(out_ovf)
  );

  complex_dot_accum #(.DATA_W(32), .TERMS(1), .GUARD_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(t1_in_valid), .in_ready(t1_in_ready), .in_re(t1_in_re), .in_im(t1_in_im),
    .flush(1'b0),
    .out_valid(t1_out_valid), .out_ready(t1_out_ready),
    .out_re(t1_out_re), .out_im(t1_out_im), .out_ovf(t1_out_ovf)
  );

  typedef struct {
    string            name;
    logic [3:0][31:0] re;
    logic [3:0][31:0] im;
    logic [31:0]      exp_re;
    logic [31:0]      exp_im;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] re, input logic [31:0] im);
    in_re = re;
    in_im = im;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"basic", {32'h00004000, 32'hFFFF8000, 32'h0, 32'h00010000},
                {32'hFFFFC000, 32'h00004000, 32'h00010000, 32'h0},
                32'h0000C000, 32'h00010000, 1'b0};
    vecs[1] = '{"pos_ovf", {4{32'h7FFFFFFF}}, {4{32'h0}},
                SAT ? 32'h7FFFFFFF : 32'hFFFFFFFC, 32'h0, 1'b1};
    vecs[2] = '{"neg_ovf", {4{32'h80000000}}, {4{32'h0}},
                SAT ? 32'h80000000 : 32'h00000000, 32'h0, 1'b1};
    vecs[3] = '{"im_ovf", {32'hFFFFFFFF, 32'd3, 32'd2, 32'd1}, {4{32'hC0000000}},
                32'd5, SAT ? 32'h80000000 : 32'h00000000, 1'b1};
    vecs[4] = '{"edge_pos", {4{32'h20000000}},
                {32'h1FFFFFFF, 32'h20000000, 32'h20000000, 32'h20000000},
                SAT ? 32'h7FFFFFFF : 32'h80000000, 32'h7FFFFFFF, 1'b1};
    vecs[5] = '{"edge_neg", {4{32'hE0000000}}, {4{32'hFFFFFFFF}},
                32'h80000000, 32'hFFFFFFFC, 1'b0};

    // Reset state, with in_valid high to confirm nothing is accepted.
    in_valid = 1'b1;
    in_re = 32'h12345678;
    repeat (3) tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_re", out_re, 32'h0);
    chk("rst_out_im", out_im, 32'h0);
    chk("rst_out_ovf", {31'b0, out_ovf}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Table-driven groups.
    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < 4; b++) begin
        send(vecs[v].re[b], vecs[v].im[b]);
        if (b == 2) chk({vecs[v].name, "_early"}, {31'b0, out_valid}, 32'd0);
      end
      chk({vecs[v].name, "_valid"}, {31'b0, out_valid}, 32'd1);
      chk({vecs[v].name, "_ready"}, {31'b0, in_ready}, 32'd0);
      chk({vecs[v].name, "_re"}, out_re, vecs[v].exp_re);
      chk({vecs[v].name, "_im"}, out_im, vecs[v].exp_im);
      chk({vecs[v].name, "_ovf"}, {31'b0, out_ovf}, {31'b0, vecs[v].exp_ovf});
      consume();
      chk({vecs[v].name, "_release"}, {31'b0, out_valid}, 32'd0);
    end

    // Backpressure: 5 stalled cycles with in_valid and flush driven; all ignored.
    send(32'h00010000, 32'h0);
    send(32'h0, 32'h00010000);
    send(32'hFFFF8000, 32'h00004000);
    send(32'h00004000, 32'hFFFFC000);
    in_valid = 1'b1;
    in_re = 32'h7FFFFFFF;
    for (int c = 0; c < 5; c++) begin
      flush = (c == 2);
      tick();
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_re", out_re, 32'h0000C000);
      chk("bp_im", out_im, 32'h00010000);
    end
    flush = 1'b0;
    in_valid = 1'b0;
    consume();
    for (int b = 0; b < 4; b++) send(32'h00008000, 32'h0);
    chk("bp_next_re", out_re, 32'h00020000);
    chk("bp_next_im", out_im, 32'h0);
    consume();

    // Flush wins over a coincident beat.
    send(32'h00010000, 32'h0);
    send(32'h00010000, 32'h0);
    in_re = 32'h00010000;
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int b = 0; b < 3; b++) send(32'h00010000, 32'h0);
    chk("flush_early", {31'b0, out_valid}, 32'd0);
    send(32'h00010000, 32'h0);
    chk("flush_valid", {31'b0, out_valid}, 32'd1);
    chk("flush_re", out_re, 32'h00040000);
    consume();

    // Asynchronous reset mid-group.
    for (int b = 0; b < 3; b++) send(32'h00010000, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("amid_valid", {31'b0, out_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int b = 0; b < 4; b++) send(32'h00008000, 32'h0);
    chk("amid_re", out_re, 32'h00020000);
    chk("amid_valid2", {31'b0, out_valid}, 32'd1);

    // Asynchronous reset while holding a result: clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("ahold_valid", {31'b0, out_valid}, 32'd0);
    chk("ahold_re", out_re, 32'h0);
    chk("ahold_ready", {31'b0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // TERMS=1: every beat is a result, ACCUM and HOLD alternate.
    t1_in_valid = 1'b1;
    t1_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      t1_in_re = 32'h00010000 * (i + 1);
      t1_in_im = 32'hFFFF0000 - i;
      tick();
      chk("t1_valid", {31'b0, t1_out_valid}, 32'd1);
      chk("t1_re", t1_out_re, 32'h00010000 * (i + 1));
      chk("t1_im", t1_out_im, 32'hFFFF0000 - i);
      chk("t1_ovf", {31'b0, t1_out_ovf}, 32'd0);
      t1_in_re = 32'hDEADBEEF;
      tick();
      chk("t1_gap", {31'b0, t1_out_valid}, 32'd0);
    end
    t1_in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
